// File: rtl/fft_stage_scheduler_if.sv
// Handshake bundle between the FFT control FSM, the stage scheduler and the
// butterfly/RAM datapath. The scheduler side uses the master modport.
interface fft_stage_scheduler_if #(
    parameter int ADDR_WIDTH = 12
);
    logic                  start;
    logic                  abort;
    logic [3:0]            log2_n;
    logic                  bf_valid;
    logic                  bf_ready;
    logic [ADDR_WIDTH-1:0] bf_addr_a;
    logic [ADDR_WIDTH-1:0] bf_addr_b;
    logic [ADDR_WIDTH-2:0] bf_tw_idx;
    logic [3:0]            bf_stage;
    logic                  bf_done;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport master (
        input  start, abort, log2_n, bf_ready, bf_done,
        output bf_valid, bf_addr_a, bf_addr_b, bf_tw_idx, bf_stage, busy, done, err
    );

    modport slave (
        output start, abort, log2_n, bf_ready, bf_done,
        input  bf_valid, bf_addr_a, bf_addr_b, bf_tw_idx, bf_stage, busy, done, err
    );
endinterface

// File: rtl/fft_stage_scheduler.sv
// Radix-2 DIT FFT stage sequencer: issues butterfly commands stage by stage and
// holds a barrier between stages until every issued butterfly has been written back.
module fft_stage_scheduler #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    fft_stage_scheduler_if.master bus
);
    localparam int KW = ADDR_WIDTH - 1;
    localparam logic [ADDR_WIDTH-1:0] ONE    = ADDR_WIDTH'(1);
    localparam logic [KW-1:0]         K_ONES = '1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FIN} state_t;

    state_t                state, state_nx;
    logic [3:0]            stage, stage_nx;
    logic [3:0]            len, len_nx;
    logic [KW-1:0]         k, k_nx;
    logic [ADDR_WIDTH-1:0] outstanding, outstanding_nx;
    logic                  err_nx;
    logic                  xfer;
    logic                  log2_ok;
    logic                  k_last;
    logic [KW-1:0]         mask, j, grp;
    logic [ADDR_WIDTH-1:0] addr_a_nx, addr_b_nx;
    logic [KW-1:0]         tw_nx;

    assign xfer    = bus.bf_valid && bus.bf_ready;
    assign log2_ok = (bus.log2_n != 4'd0) && (int'(bus.log2_n) <= ADDR_WIDTH);
    // Last butterfly of a stage is k = 2^(L-1) - 1.
    assign k_last  = (k == ~(K_ONES << (len - 4'd1)));

    always_comb begin
        state_nx = state;
        stage_nx = stage;
        len_nx   = len;
        k_nx     = k;
        err_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (log2_ok) begin
                        state_nx = ISSUE;
                        stage_nx = '0;
                        k_nx     = '0;
                        len_nx   = bus.log2_n;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (xfer) begin
                    if (k_last) state_nx = WAIT;
                    else        k_nx     = k + KW'(1);
                end
            end
            WAIT: begin
                if (outstanding == '0) begin
                    if (stage == len - 4'd1) begin
                        state_nx = FIN;
                    end else begin
                        state_nx = ISSUE;
                        stage_nx = stage + 4'd1;
                        k_nx     = '0;
                    end
                end
            end
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (bus.abort) begin
            state_nx = IDLE;
            stage_nx = '0;
            k_nx     = '0;
            err_nx   = 1'b0;
        end
    end

    // A write-back in the same cycle as an issue cancels out, even from zero.
    always_comb begin
        outstanding_nx = outstanding;
        if (bus.abort)
            outstanding_nx = '0;
        else if (xfer && !bus.bf_done)
            outstanding_nx = outstanding + ONE;
        else if (!xfer && bus.bf_done && (outstanding != '0))
            outstanding_nx = outstanding - ONE;
    end

    // Payload for the next cycle's (stage, k): A = grp*2*half + j, B = A + half.
    always_comb begin
        mask      = ~(K_ONES << stage_nx);
        j         = k_nx & mask;
        grp       = k_nx >> stage_nx;
        addr_a_nx = ({1'b0, grp} << (stage_nx + 4'd1)) | {1'b0, j};
        addr_b_nx = addr_a_nx + (ONE << stage_nx);
        tw_nx     = j << (len_nx - 4'd1 - stage_nx);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            stage         <= '0;
            len           <= '0;
            k             <= '0;
            outstanding   <= '0;
            bus.bf_valid  <= 1'b0;
            bus.bf_addr_a <= '0;
            bus.bf_addr_b <= '0;
            bus.bf_tw_idx <= '0;
            bus.bf_stage  <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
        end else begin
            state         <= state_nx;
            stage         <= stage_nx;
            len           <= len_nx;
            k             <= k_nx;
            outstanding   <= outstanding_nx;
            bus.bf_valid  <= (state_nx == ISSUE);
            bus.bf_addr_a <= addr_a_nx;
            bus.bf_addr_b <= addr_b_nx;
            bus.bf_tw_idx <= tw_nx;
            bus.bf_stage  <= stage_nx;
            bus.busy      <= (state_nx == ISSUE) || (state_nx == WAIT);
            bus.done      <= (state_nx == FIN);
            bus.err       <= err_nx;
        end
    end
endmodule

// File: doc/fft_stage_scheduler.md
# fft_stage_scheduler

Sequencer for the in-place radix-2 decimation-in-time FFT datapath. It walks all log2(N) stages and issues one butterfly command per handshake: the A/B RAM addresses and the twiddle index. Before starting the next stage it waits until every butterfly of the current stage has been written back. It sits between the top-level control FSM, which starts it once samples are loaded in bit-reversed order, and the butterfly/RAM datapath.

## Interface
- ADDR_WIDTH, 12: sample RAM address width; maximum N = 2^ADDR_WIDTH.
- clk  in  1  clock; all logic is on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- START  in  1  single-cycle request to begin a transform; sampled only in IDLE.
- ABORT  in  1  synchronous abort; returns to IDLE next cycle.
- LOG2_N  in  4  log2 of transform size; valid range 1..ADDR_WIDTH; sampled with START.
- BF_VALID  out  1  butterfly command valid.
- BF_READY  in  1  datapath accepts the command.
- BF_ADDR_A  out  ADDR_WIDTH  address of the upper butterfly input.
- BF_ADDR_B  out  ADDR_WIDTH  address of the lower butterfly input (A + half).
- BF_TW_IDX  out  ADDR_WIDTH-1  twiddle ROM index.
- BF_STAGE  out  4  current stage number s.
- BF_DONE  in  1  one pulse per completed butterfly write-back.
- BUSY  out  1  high from the cycle after an accepted START until DONE.
- DONE  out  1  single-cycle pulse at transform completion.
- ERR  out  1  single-cycle pulse when START arrives with an invalid LOG2_N.

## Operation
- States:
  - IDLE: START with a valid LOG2_N → ISSUE, s=0, k=0, L latched. START with an invalid LOG2_N → stay in IDLE, ERR pulses.
  - ISSUE: presents butterfly k of stage s.
  - WAIT: stage barrier.
  - FIN: DONE pulses, then → IDLE.
- Address generation for stage s, butterfly k (k = 0..N/2-1):
  - half = 2^s, j = k & (half-1), grp = k >> s.
  - A = grp·2·half + j, B = A + half.
  - TW = j << (L-1-s).
  - All arithmetic is unsigned at ADDR_WIDTH bits; no overflow is possible within the valid LOG2_N range.
- Transfer occurs on a cycle where BF_VALID && BF_READY.
  - After a transfer, k increments.
  - After transferring k = N/2-1, go to WAIT.
- Outstanding counter (ADDR_WIDTH bits):
  - +1 on transfer, −1 on BF_DONE; a simultaneous transfer and BF_DONE leaves it unchanged.
  - BF_DONE while the counter is 0 is ignored; the counter never underflows.
- WAIT exits when the outstanding counter register reads 0.
  - If s = L-1 → FIN.
  - Otherwise s+1, k=0 → ISSUE.
- START outside IDLE is ignored.
- ABORT in any state (and Reset) has these effects:
  - Next state is IDLE.
  - Counters clear and in-flight BF_DONEs are discarded.
  - BF_VALID=0 and BUSY=0, with no DONE pulse.
  - Reset has priority over ABORT; ABORT has priority over START.

## Timing
- Reset values:
  - BF_VALID=0, BF_ADDR_A=0, BF_ADDR_B=0, BF_TW_IDX=0, BF_STAGE=0.
  - BUSY=0, DONE=0, ERR=0.
  - State IDLE, outstanding counter 0.
- All outputs are registered.
- START at edge t → BUSY=1 and BF_VALID=1 with k=0 from cycle t+1.
- While BF_VALID=1 and BF_READY=0, the payload is held stable. BF_VALID never deasserts without a transfer, except on ABORT or Reset.
- With BF_READY held high, one butterfly is issued per cycle with no bubbles inside a stage.
- BF_VALID=0 throughout WAIT.
- Stage gap: when the counter reads 0 at edge t in WAIT, the first butterfly of the next stage is valid at t+1.
- DONE is high for the one cycle following the final WAIT exit. BUSY falls in that same cycle.
- ERR asserts in the cycle after the invalid START.
- Minimum transform time with zero write-back latency: L·(N/2) issue cycles plus L WAIT cycles plus 1.

## Test plan
- LOG2_N=3, BF_READY=1, BF_DONE echoed 2 cycles after each transfer → the transfer sequence (A,B,TW) must be:
  - stage 0: (0,1,0)(2,3,0)(4,5,0)(6,7,0)
  - stage 1: (0,2,0)(1,3,2)(4,6,0)(5,7,2)
  - stage 2: (0,4,0)(1,5,1)(2,6,2)(3,7,3)
  - DONE pulses once, 12 transfers total.
- Same run with BF_READY toggling pseudo-randomly → identical transfer sequence, payload stable during stalls, no duplicated or skipped k.
- Write-back delay of 10 cycles → the first stage-1 transfer does not occur before the 4th BF_DONE. Simultaneous transfer and BF_DONE cycles keep the count exact.
- LOG2_N=0 and LOG2_N=13 with START → ERR pulses, BUSY stays 0, no BF_VALID. LOG2_N=1 → a single (0,1,0) butterfly, then DONE.
- Mid-stage-1 ABORT, then Reset during WAIT, with BF_DONE pulses still arriving → IDLE next cycle, BUSY=0, no DONE, stale BF_DONEs ignored. A subsequent START runs a clean full transform.
- START pulsed while BUSY, and a spurious BF_DONE in IDLE → no effect on the sequence or counter.
